decode_issue_queue: RTL and testbench
=====================================

# decode_issue_queue

Decoupling FIFO between the decode stage and the issue stage. It buffers decoded scoreboard entries and presents them to the issue stage's rename/scoreboard input with a valid/ack handshake. It also stalls issue behind any unresolved control-flow instruction, holding at most one branch in flight. A flush discards all buffered entries.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥2
- OCC_W, $clog2(DEPTH)+1, occupancy counter width (derived, not overridden)

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- flush_i  in  1  discard all entries, clear branch-pending state
- decoded_instr_i  in  scoreboard_entry_t  decoded instruction from decode
- decoded_instr_valid_i  in  1  decode presents an entry
- is_ctrl_flow_i  in  1  entry is a branch or jump
- decoded_instr_ack_o  out  1  entry accepted this cycle
- issue_instr_o  out  scoreboard_entry_t  head entry to issue stage
- issue_instr_valid_o  out  1  head entry valid and not gated
- issue_is_ctrl_flow_o  out  1  head entry is control flow
- issue_ack_i  in  1  issue stage consumed head entry
- resolve_branch_i  in  1  EX resolved the outstanding control-flow instruction
- occupancy_o  out  OCC_W  number of stored entries
- full_o  out  1  occupancy == DEPTH

One clock, clk_i. Reset rst_ni is asynchronous and active-low.

## Operation
- Storage: circular buffer of DEPTH entries. Each entry holds {scoreboard_entry_t, ctrl_flow bit}. Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count is OCC_W bits.
- Enqueue fires when decoded_instr_valid_i && decoded_instr_ack_o.
- decoded_instr_ack_o = !full && !flush_i. It depends only on registered state and flush_i. It has no path from issue_ack_i, so a full queue rejects input even in a cycle where it dequeues.
- Dequeue fires when issue_instr_valid_o && issue_ack_i.
- issue_instr_valid_o = (count != 0) && !branch_pending && !flush_i.
- issue_instr_o and issue_is_ctrl_flow_o always show the head slot. They are don't-care when valid is low.
- branch_pending flag:
  - Set when a dequeued entry has ctrl_flow = 1.
  - Cleared by resolve_branch_i.
  - If set and resolve occur in the same cycle, set wins.
  - resolve_branch_i while not pending is ignored.
- Simultaneous enqueue and dequeue: count is unchanged and both pointers advance.
- Flush: on the next edge, both pointers and count are set to 0 and branch_pending is cleared. Any enqueue or dequeue in the flush cycle is suppressed.
- Reset mid-operation: all state is cleared asynchronously. Contents are lost.

## Timing
- Reset values:
  - decoded_instr_ack_o = 1 (if flush_i = 0)
  - issue_instr_valid_o = 0
  - issue_is_ctrl_flow_o = 0
  - occupancy_o = 0
  - full_o = 0
  - branch_pending = 0
- Latency without bypass: an entry enqueued at edge N is visible at the output in cycle N+1.
- Throughput is 1 entry/cycle in steady state when not full and not gated.
- Gating: after a control-flow entry is dequeued at edge N, valid is low from cycle N+1. Valid stays low until the cycle after resolve_branch_i is sampled high.
- occupancy_o and full_o are registered.

## Configuration
- CVA6_DIQ_BYPASS_EN defined:
  - When count == 0, !branch_pending and !flush_i, the input entry passes combinationally to the output.
  - In that case issue_instr_valid_o = decoded_instr_valid_i.
  - If issue_ack_i is high in the same cycle, the entry is consumed and not written. It still sets branch_pending if it is control flow.
  - Otherwise it is written normally.
  - Latency is 0 cycles on an empty queue.
- Undefined: no bypass. Minimum latency is 1 cycle, and there is no combinational path from input to output.

## Test plan
- Fill and drain:
  - Stimulus: enqueue 4 non-branch entries (DEPTH=4) with issue_ack_i low.
  - Required: full_o = 1, decoded_instr_ack_o = 0, occupancy_o = 4.
  - Then assert issue_ack_i for 4 cycles. Required: entries emerge in order and occupancy_o returns to 0.
- Wrap-around:
  - Stimulus: stream 10 entries with continuous ack, alternating idle cycles.
  - Required: output order matches input order; pointers wrap cleanly.
- Control-flow gating:
  - Stimulus: enqueue {branch, add, sub}; ack the branch.
  - Required: valid stays low for 3 cycles until resolve_branch_i pulses. The add appears the cycle after the pulse.
- Set/resolve collision:
  - Stimulus: resolve_branch_i high while not pending, in the same cycle a jump is dequeued.
  - Required: branch_pending = 1 afterwards and the next entry is held.
- Flush:
  - Stimulus: with 3 entries queued and a branch pending, assert flush_i concurrently with decoded_instr_valid_i = 1.
  - Required: decoded_instr_ack_o = 0 that cycle, occupancy_o = 0 next cycle, branch_pending cleared.
- Bypass (CVA6_DIQ_BYPASS_EN defined):
  - Stimulus: empty queue, valid input with issue_ack_i = 1.
  - Required: issue_instr_valid_o = 1 in the same cycle and occupancy_o stays 0.
  - Without the macro, valid first appears one cycle later.

Source files
------------

// File: rtl/decode_issue_queue.sv
// Decode-to-issue decoupling FIFO with single-branch-in-flight gating and flush.
// Optional combinational empty-queue bypass is enabled by defining CVA6_DIQ_BYPASS_EN.

package decode_issue_queue_pkg;
  typedef struct packed {
    logic [31:0] pc;
    logic [3:0]  fu;
    logic [4:0]  rd;
  } scoreboard_entry_t;
endpackage

module decode_issue_queue
  import decode_issue_queue_pkg::*;
#(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              flush_i,
  input  scoreboard_entry_t decoded_instr_i,
  input  logic              decoded_instr_valid_i,
  input  logic              is_ctrl_flow_i,
  output logic              decoded_instr_ack_o,
  output scoreboard_entry_t issue_instr_o,
  output logic              issue_instr_valid_o,
  output logic              issue_is_ctrl_flow_o,
  input  logic              issue_ack_i,
  input  logic              resolve_branch_i,
  output logic [OCC_W-1:0]  occupancy_o,
  output logic              full_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  typedef struct packed {
    scoreboard_entry_t instr;
    logic              ctrl_flow;
  } slot_t;

  slot_t             mem [DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [OCC_W-1:0]  count;
  logic              branch_pending;

  logic full;
  logic empty;
  logic bypass;
  logic enq;
  logic deq;
  logic wr_en;
  logic rd_en;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    full                 = (count == OCC_W'(DEPTH));
    empty                = (count == '0);
    decoded_instr_ack_o  = !full && !flush_i;
    issue_instr_o        = mem[rd_ptr].instr;
    // Head slot is not reset, so mask the flag to keep it clean while empty.
    issue_is_ctrl_flow_o = mem[rd_ptr].ctrl_flow && !empty;
    issue_instr_valid_o  = !empty && !branch_pending && !flush_i;
`ifdef CVA6_DIQ_BYPASS_EN
    bypass = empty && !branch_pending && !flush_i;
    if (bypass) begin
      issue_instr_o        = decoded_instr_i;
      issue_is_ctrl_flow_o = is_ctrl_flow_i;
      issue_instr_valid_o  = decoded_instr_valid_i;
    end
`else
    bypass = 1'b0;
`endif
    enq   = decoded_instr_valid_i && decoded_instr_ack_o;
    deq   = issue_instr_valid_o && issue_ack_i;
    // A bypassed entry consumed in the same cycle never touches storage.
    wr_en = enq && !(bypass && issue_ack_i);
    rd_en = deq && !bypass;
  end

  assign occupancy_o = count;
  assign full_o      = full;

  // NOTE: storage is deliberately not reset; count and pointers alone define validity.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_ptr] <= '{instr: decoded_instr_i, ctrl_flow: is_ctrl_flow_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      branch_pending <= 1'b0;
    end else if (flush_i) begin
      rd_ptr         <= '0;
      wr_ptr         <= '0;
      count          <= '0;
      branch_pending <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (rd_en) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({wr_en, rd_en})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
      // Issuing a new control-flow entry outranks a same-cycle resolve.
      if (deq && issue_is_ctrl_flow_o) begin
        branch_pending <= 1'b1;
      end else if (resolve_branch_i) begin
        branch_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_issue_queue.sv
// Directed bench for decode_issue_queue: a queue-based scoreboard predicts every
// handshake and head entry; follows CVA6_DIQ_BYPASS_EN when it is defined.

module tb_decode_issue_queue;
  import decode_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned OCC_W = $clog2(DEPTH) + 1;

  typedef struct packed {
    scoreboard_entry_t e;
    logic              cf;
  } item_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic              flush_i;
  scoreboard_entry_t decoded_instr_i;
  logic              decoded_instr_valid_i;
  logic              is_ctrl_flow_i;
  logic              decoded_instr_ack_o;
  scoreboard_entry_t issue_instr_o;
  logic              issue_instr_valid_o;
  logic              issue_is_ctrl_flow_o;
  logic              issue_ack_i;
  logic              resolve_branch_i;
  logic [OCC_W-1:0]  occupancy_o;
  logic              full_o;

  int    vectors     = 0;
  int    miscompares = 0;
  item_t sb[$];
  logic  bp = 1'b0;

  decode_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk_i                 (clk_i),
    .rst_ni                (rst_ni),
    .flush_i               (flush_i),
    .decoded_instr_i       (decoded_instr_i),
    .decoded_instr_valid_i (decoded_instr_valid_i),
    .is_ctrl_flow_i        (is_ctrl_flow_i),
    .decoded_instr_ack_o   (decoded_instr_ack_o),
    .issue_instr_o         (issue_instr_o),
    .issue_instr_valid_o   (issue_instr_valid_o),
    .issue_is_ctrl_flow_o  (issue_is_ctrl_flow_o),
    .issue_ack_i           (issue_ack_i),
    .resolve_branch_i      (resolve_branch_i),
    .occupancy_o           (occupancy_o),
    .full_o                (full_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic scoreboard_entry_t mk(input int i);
    scoreboard_entry_t r;
    r.pc = 32'h1000 + 32'(i) * 32'd4;
    r.fu = 4'(i);
    r.rd = 5'(i + 1);
    return r;
  endfunction

  // Drives one cycle, checks the DUT at the falling edge against the scoreboard,
  // then advances the scoreboard as of the following rising edge.
  task automatic cycle(input logic v, input int idx, input logic cf,
                       input logic ack, input logic res, input logic fl);
    logic  byp;
    logic  exp_ack;
    logic  exp_valid;
    logic  set_bp;
    item_t head;
    decoded_instr_valid_i = v;
    decoded_instr_i       = mk(idx);
    is_ctrl_flow_i        = cf;
    issue_ack_i           = ack;
    resolve_branch_i      = res;
    flush_i               = fl;
    @(negedge clk_i);
    byp = 1'b0;
`ifdef CVA6_DIQ_BYPASS_EN
    byp = (sb.size() == 0) && !bp && !fl;
`endif
    exp_ack   = (sb.size() != DEPTH) && !fl;
    exp_valid = byp ? v : ((sb.size() != 0) && !bp && !fl);
    head      = byp ? '{e: mk(idx), cf: cf} : ((sb.size() != 0) ? sb[0] : '0);
    check("ack", 64'(decoded_instr_ack_o), 64'(exp_ack));
    check("valid", 64'(issue_instr_valid_o), 64'(exp_valid));
    check("occupancy", 64'(occupancy_o), 64'(sb.size()));
    check("full", 64'(full_o), 64'(sb.size() == DEPTH));
    if (exp_valid) begin
      check("head_instr", 64'(issue_instr_o), 64'(head.e));
      check("head_ctrl", 64'(issue_is_ctrl_flow_o), 64'(head.cf));
    end
    if (fl) begin
      sb.delete();
      bp = 1'b0;
    end else begin
      set_bp = exp_valid && ack && head.cf;
      if (exp_valid && ack && !byp) void'(sb.pop_front());
      if (v && exp_ack && !(byp && ack)) sb.push_back('{e: mk(idx), cf: cf});
      if (set_bp) bp = 1'b1;
      else if (res) bp = 1'b0;
    end
    @(posedge clk_i);
    #1;
  endtask

  initial begin
    rst_ni                = 1'b0;
    flush_i               = 1'b0;
    decoded_instr_i       = '0;
    decoded_instr_valid_i = 1'b0;
    is_ctrl_flow_i        = 1'b0;
    issue_ack_i           = 1'b0;
    resolve_branch_i      = 1'b0;

    // Reset values
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    check("rst_ack", 64'(decoded_instr_ack_o), 64'd1);
    check("rst_valid", 64'(issue_instr_valid_o), 64'd0);
    check("rst_ctrl", 64'(issue_is_ctrl_flow_o), 64'd0);
    check("rst_occ", 64'(occupancy_o), 64'd0);
    check("rst_full", 64'(full_o), 64'd0);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // Fill to full, one rejected offer, then drain in order
    for (int i = 0; i < 4; i++) cycle(1'b1, i, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 99, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Full queue rejects input even while dequeuing
    for (int i = 0; i < 4; i++) cycle(1'b1, 10 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 98, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Wrap-around: 10 entries, continuous ack, idle cycle between entries
    for (int i = 0; i < 20; i++) cycle(i % 2 == 0, 20 + i / 2, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Back-to-back streaming with continuous ack
    for (int i = 0; i < 6; i++) cycle(1'b1, 40 + i, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Control-flow gating: {branch, add, sub}
    cycle(1'b1, 50, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 51, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 52, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Set/resolve collision: resolve while idle, same cycle as a jump issues
    cycle(1'b1, 60, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 61, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Flush with three entries queued behind a pending branch
    cycle(1'b1, 70, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 4; i++) cycle(1'b1, 70 + i, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 79, 1'b0, 1'b1, 1'b0, 1'b1);
    cycle(1'b1, 80, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Empty queue, valid input with ack: same-cycle issue only with bypass
    cycle(1'b1, 90, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 91, 1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b1, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-operation
    cycle(1'b1, 95, 1'b1, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 96, 1'b0, 1'b1, 1'b0, 1'b0);
    decoded_instr_valid_i = 1'b0;
    issue_ack_i           = 1'b0;
    is_ctrl_flow_i        = 1'b0;
    #2;
    rst_ni = 1'b0;
    #1;
    check("async_rst_occ", 64'(occupancy_o), 64'd0);
    check("async_rst_valid", 64'(issue_instr_valid_o), 64'd0);
    check("async_rst_ack", 64'(decoded_instr_ack_o), 64'd1);
    sb.delete();
    bp = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    cycle(1'b1, 97, 1'b0, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b1, 1'b0, 1'b0);
    cycle(1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
